// File: rtl/evt_scheduler.sv
// Multi-channel periodic event scheduler: per-channel evt_in counters feeding a round-robin valid/ready arbiter.
// Optional build macro EVT_SCHED_OVERRUN_EN adds sticky per-channel overrun flags.
module evt_scheduler #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      evt_in,
  input  logic                      cfg_we_in,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch_in,
  input  logic [WIDTH-1:0]          cfg_period_in,
  input  logic                      cfg_en_in,
  output logic                      exp_valid_out,
  output logic [$clog2(NUM_CH)-1:0] exp_ch_out,
  input  logic                      exp_ready_in,
  output logic [NUM_CH-1:0]         pending_out,
  output logic [NUM_CH-1:0]         overrun_out
);

  // state    | meaning
  // ST_IDLE    | nothing presented, exp_valid_out=0
  // ST_PRESENT | expiry of ch_q presented, held until exp_ready_in
  localparam int CW = $clog2(NUM_CH);
  localparam logic [WIDTH-1:0] ONE = 1;

  typedef enum logic {ST_IDLE, ST_PRESENT} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [CW-1:0]     ptr_q, ptr_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [WIDTH-1:0]  period_q [NUM_CH];
  logic [WIDTH-1:0]  period_d [NUM_CH];
  logic [WIDTH-1:0]  count_q  [NUM_CH];
  logic [WIDTH-1:0]  count_d  [NUM_CH];

  logic              accept;
  logic [NUM_CH-1:0] acc_mask;
  logic [NUM_CH-1:0] expire;
  logic [NUM_CH-1:0] cfg_hit;
  logic [NUM_CH-1:0] pend_m;
  logic [CW-1:0]     eff_ptr;
  logic [CW-1:0]     sel;
  logic              found;
  int                idx;

  assign accept   = (state_q == ST_PRESENT) && exp_ready_in;
  assign acc_mask = accept ? (NUM_CH'(1) << ch_q) : '0;

  // Counters: the match is done one bit wider so count+1 never wraps onto period.
  always_comb begin
    en_d    = en_q;
    expire  = '0;
    cfg_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      period_d[i] = period_q[i];
      count_d[i]  = count_q[i];
      if (cfg_we_in && (cfg_ch_in == CW'(i))) begin
        cfg_hit[i]  = 1'b1;
        period_d[i] = cfg_period_in;
        en_d[i]     = cfg_en_in;
        count_d[i]  = '0;
      end else if (evt_in && en_q[i] && (period_q[i] != '0)) begin
        if (({1'b0, count_q[i]} + {1'b0, ONE}) == {1'b0, period_q[i]}) begin
          count_d[i] = '0;
          expire[i]  = 1'b1;
        end else begin
          count_d[i] = count_q[i] + ONE;
        end
      end
    end
    pending_d = (pending_q & ~acc_mask) | expire;
  end

  // Arbiter: search starts just past the channel being accepted this cycle.
  always_comb begin
    pend_m  = pending_q & ~acc_mask;
    eff_ptr = ptr_q;
    if (accept) begin
      eff_ptr = (ch_q == CW'(NUM_CH - 1)) ? '0 : ch_q + CW'(1);
    end
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(eff_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && pend_m[idx]) begin
        found = 1'b1;
        sel   = CW'(idx);
      end
    end
    state_d = state_q;
    ch_d    = ch_q;
    ptr_d   = accept ? eff_ptr : ptr_q;
    if ((state_q == ST_IDLE) || exp_ready_in) begin
      if (found) begin
        state_d = ST_PRESENT;
        ch_d    = sel;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      ptr_q     <= '0;
      pending_q <= '0;
      en_q      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        period_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      en_q      <= en_d;
      for (int i = 0; i < NUM_CH; i++) begin
        period_q[i] <= period_d[i];
        count_q[i]  <= count_d[i];
      end
    end
  end

`ifdef EVT_SCHED_OVERRUN_EN
  logic [NUM_CH-1:0] overrun_q, overrun_d;

  // expire is already suppressed on a cfg write, so clear and set never collide.
  always_comb begin
    overrun_d = (overrun_q & ~cfg_hit) | (expire & pending_q & ~acc_mask);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      overrun_q <= '0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun_out = overrun_q;
`else
  logic unused_cfg_hit;
  assign unused_cfg_hit = ^cfg_hit;
  assign overrun_out    = '0;
`endif

  assign exp_valid_out = (state_q == ST_PRESENT);
  assign exp_ch_out    = ch_q;
  assign pending_out   = pending_q;

endmodule
